// File: rtl/adc_pkg.sv
// Shared definitions for the ADC averaging / BCD conversion path.
// FSM state encodings, result widths and the leading-zero blank decode.
package adc_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCALE = 2'd1,
    S_CONV  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int BCD_W = 16;
  localparam int MV_W  = 14;

  // Blank mask for the display driver: bit3 = thousands. Units are always shown.
  function automatic logic [3:0] blank_mask(input logic [BCD_W-1:0] bcd);
    logic [3:0] m;
    m[3] = (bcd[15:12] == 4'd0);
    m[2] = m[3] && (bcd[11:8] == 4'd0);
    m[1] = m[2] && (bcd[7:4] == 4'd0);
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 14-bit binary to 4-digit packed BCD, one bit per cycle.
// i_start loads the operand; the next 14 cycles each run one add-3/shift step.
// o_done flags the cycle of the final step and o_bcd carries the value that step
// produces, so the caller can register the result on the same edge.
module bin2bcd_seq
  import adc_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [MV_W-1:0]  i_bin,
  output logic             o_done,
  output logic [BCD_W-1:0] o_bcd
);

  logic [MV_W-1:0]  r_bin;
  logic [BCD_W-1:0] r_bcd;
  logic [3:0]       r_cnt;
  logic             r_act;

  logic [BCD_W-1:0] w_adj;
  logic [BCD_W-1:0] w_step;

  // Add 3 to every nibble >= 5, then shift in the next binary bit MSB first.
  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < 4; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
    w_step = {w_adj[BCD_W-2:0], r_bin[MV_W-1]};
  end

  assign o_done = r_act && (r_cnt == 4'(MV_W - 1));
  assign o_bcd  = w_step;

  // Operand/partial-result shift registers and step counter.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_act <= 1'b0;
    end else if (i_start) begin
      r_bin <= i_bin;
      r_bcd <= '0;
      r_cnt <= '0;
      r_act <= 1'b1;
    end else if (r_act) begin
      r_bcd <= w_step;
      r_bin <= r_bin << 1;
      r_cnt <= r_cnt + 4'd1;
      if (r_cnt == 4'(MV_W - 1)) r_act <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_avg_bcd.sv
// Box-car averager for 8-bit ADC codes, scaled to millivolts and converted to
// 4-digit BCD for the segment display.
// Optional feature macro: ADC_BCD_BLANK_EN enables the leading-zero blank mask;
// without it o_blank is held at zero.
module adc_avg_bcd
  import adc_pkg::*;
#(
  parameter int AVG_LOG2 = 2,
  parameter int VREF_MV  = 5000
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_sample,
  input  logic             i_sample_vld,
  output logic [7:0]       o_mean,
  output logic [BCD_W-1:0] o_bcd,
  output logic             o_bcd_vld,
  output logic             o_busy,
  output logic             o_overrun,
  output logic [3:0]       o_blank
);

  localparam int ACC_W = 8 + AVG_LOG2;
  // One extra bit keeps the counter non-zero width when AVG_LOG2 = 0.
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_mean;

  state_e           r_state;
  logic [7:0]       r_mean_l;
  logic             r_pend;
  logic             r_over;
  logic [BCD_W-1:0] r_bcd;
  logic             r_bcd_vld;
  logic [3:0]       r_blank;

  logic [ACC_W-1:0] w_sum;
  logic             w_win_done;
  logic [7:0]       w_mean_new;
  logic [MV_W-1:0]  w_mv;
  logic             w_conv_done;
  logic [BCD_W-1:0] w_bcd_step;
  logic [3:0]       w_blank_nxt;

  // Window sum cannot overflow: at most 2**AVG_LOG2 * 255 < 2**ACC_W.
  assign w_sum      = r_acc + ACC_W'(i_sample);
  assign w_win_done = i_sample_vld && (r_cnt == CNT_LAST);
  assign w_mean_new = 8'(w_sum >> AVG_LOG2);

  // Scaled value is formed from the latched mean during SCALE and captured by
  // the converter's operand register on the SCALE->CONV edge.
  assign w_mv = MV_W'((22'(r_mean_l) * 22'(VREF_MV)) >> 8);

`ifdef ADC_BCD_BLANK_EN
  assign w_blank_nxt = blank_mask(w_bcd_step);
`else
  assign w_blank_nxt = 4'b0000;
`endif

  // Accumulator: never stalls; a partial window is held until more samples arrive.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_mean <= '0;
    end else if (i_sample_vld) begin
      if (w_win_done) begin
        r_acc  <= '0;
        r_cnt  <= '0;
        r_mean <= w_mean_new;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Scale/convert sequencer with pending-window and overrun tracking.
  // While pending, the mean to convert is always r_mean (the newest window).
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= S_IDLE;
      r_mean_l  <= '0;
      r_pend    <= 1'b0;
      r_over    <= 1'b0;
      r_bcd     <= '0;
      r_bcd_vld <= 1'b0;
      r_blank   <= '0;
    end else begin
      r_bcd_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_pend) begin
            // Serve the pending window; a window finishing now becomes the next pending one.
            r_state  <= S_SCALE;
            r_mean_l <= r_mean;
            r_pend   <= w_win_done;
          end else if (w_win_done) begin
            r_state  <= S_SCALE;
            r_mean_l <= w_mean_new;
          end
        end
        S_SCALE: r_state <= S_CONV;
        S_CONV: begin
          if (w_conv_done) begin
            r_state   <= S_DONE;
            r_bcd     <= w_bcd_step;
            r_bcd_vld <= 1'b1;
            r_blank   <= w_blank_nxt;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if ((r_state != S_IDLE) && w_win_done) begin
        if (r_pend) r_over <= 1'b1;
        r_pend <= 1'b1;
      end
    end
  end

  bin2bcd_seq u_b2b (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (r_state == S_SCALE),
    .i_bin   (w_mv),
    .o_done  (w_conv_done),
    .o_bcd   (w_bcd_step)
  );

  assign o_mean    = r_mean;
  assign o_bcd     = r_bcd;
  assign o_bcd_vld = r_bcd_vld;
  assign o_busy    = (r_state != S_IDLE);
  assign o_overrun = r_over;
  assign o_blank   = r_blank;

endmodule

// File: tb/tb_adc_avg_bcd.sv
// Directed bench for adc_avg_bcd: table of full windows plus hand sequences for
// overrun, mid-conversion reset, AVG_LOG2=0 and long idle gaps.
module tb_adc_avg_bcd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  smp, smp2;
  logic        vld, vld2;
  logic [7:0]  mean, mean2;
  logic [15:0] bcd, bcd2;
  logic        bvld, bvld2, busy, busy2, ovr, ovr2;
  logic [3:0]  blank, blank2;

  always #10 clk = ~clk;

  adc_avg_bcd #(.AVG_LOG2(2), .VREF_MV(5000)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_sample(smp), .i_sample_vld(vld),
    .o_mean(mean), .o_bcd(bcd), .o_bcd_vld(bvld), .o_busy(busy),
    .o_overrun(ovr), .o_blank(blank)
  );

  adc_avg_bcd #(.AVG_LOG2(0), .VREF_MV(10000)) dut2 (
    .i_clk(clk), .i_rst(rst_n), .i_sample(smp2), .i_sample_vld(vld2),
    .o_mean(mean2), .o_bcd(bcd2), .o_bcd_vld(bvld2), .o_busy(busy2),
    .o_overrun(ovr2), .o_blank(blank2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_blank(input logic [3:0] b);
`ifdef ADC_BCD_BLANK_EN
    return b;
`else
    return (b & 4'b0000);
`endif
  endfunction

  typedef struct {
    logic [3:0][7:0] s;
    logic [7:0]      mean;
    logic [15:0]     bcd;
    logic [3:0]      blk;
  } vec_t;

  // Drive cnt strobes on consecutive cycles, leftmost sample first; leaves vld high.
  task automatic strobes(input int cnt, input logic [3:0][7:0] s);
    for (int i = 3; i > 3 - cnt; i--) begin
      @(posedge clk); #1;
      vld = 1'b1;
      smp = s[i];
    end
  endtask

  // Count cycles after the last strobe until o_bcd_vld; lat = -1 on timeout.
  task automatic wait_vld(output int lat, output logic busy1);
    lat = -1;
    busy1 = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        vld = 1'b0;
        busy1 = busy;
      end
      if (bvld) begin
        lat = n;
        break;
      end
    end
  endtask

  vec_t vt[7];
  int   lat, pulses;
  logic b1;
  logic [15:0] got[2];

  initial begin
    vt[0] = '{s: {8'd128, 8'd128, 8'd128, 8'd128}, mean: 8'd128, bcd: 16'h2500, blk: 4'b0000};
    vt[1] = '{s: {8'd255, 8'd255, 8'd255, 8'd255}, mean: 8'd255, bcd: 16'h4980, blk: 4'b0000};
    vt[2] = '{s: {8'd0,   8'd1,   8'd2,   8'd3},   mean: 8'd1,   bcd: 16'h0019, blk: 4'b1100};
    vt[3] = '{s: {8'd64,  8'd64,  8'd64,  8'd64},  mean: 8'd64,  bcd: 16'h1250, blk: 4'b0000};
    vt[4] = '{s: {8'd0,   8'd0,   8'd0,   8'd0},   mean: 8'd0,   bcd: 16'h0000, blk: 4'b1110};
    vt[5] = '{s: {8'd10,  8'd10,  8'd10,  8'd10},  mean: 8'd10,  bcd: 16'h0195, blk: 4'b1000};
    vt[6] = '{s: {8'd4,   8'd4,   8'd4,   8'd0},   mean: 8'd3,   bcd: 16'h0058, blk: 4'b1100};

    rst_n = 1'b0; vld = 1'b0; smp = '0; vld2 = 1'b0; smp2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mean", mean, 0);
    chk("rst_bcd", bcd, 0);
    chk("rst_vld", bvld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_blank", blank, 0);
    rst_n = 1'b1;

    // Full windows: latency, mean, BCD, blank, single pulse, back to idle.
    for (int v = 0; v < 7; v++) begin
      strobes(4, vt[v].s);
      wait_vld(lat, b1);
      chk($sformatf("v%0d_busy1", v), b1, 1);
      chk($sformatf("v%0d_lat", v), lat, 16);
      chk($sformatf("v%0d_mean", v), mean, vt[v].mean);
      chk($sformatf("v%0d_bcd", v), bcd, vt[v].bcd);
      chk($sformatf("v%0d_blank", v), blank, exp_blank(vt[v].blk));
      @(posedge clk); #1;
      chk($sformatf("v%0d_pulse1", v), bvld, 0);
      chk($sformatf("v%0d_idle", v), busy, 0);
      repeat (3) @(posedge clk);
    end
    chk("no_ovr_yet", ovr, 0);

    // Back-to-back windows: window 2 is overwritten by window 3.
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      vld = 1'b1;
      smp = (i < 4) ? 8'd128 : (i < 8) ? 8'd64 : 8'd255;
    end
    pulses = 0;
    got[0] = '0; got[1] = '0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        vld = 1'b0;
        chk("ovr_mean_newest", mean, 255);
        chk("ovr_set", ovr, 1);
      end
      if (bvld) begin
        if (pulses < 2) got[pulses] = bcd;
        pulses++;
      end
    end
    chk("ovr_pulses", pulses, 2);
    chk("ovr_bcd_w1", got[0], 16'h2500);
    chk("ovr_bcd_w3", got[1], 16'h4980);
    chk("ovr_sticky", ovr, 1);

    // Reset asserted mid-conversion.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("ovr_cleared", ovr, 0);
    rst_n = 1'b1;
    strobes(4, {8'd128, 8'd128, 8'd128, 8'd128});
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk); #1;
      if (n == 1) vld = 1'b0;
    end
    chk("mid_busy", busy, 1);
    chk("mid_mean", mean, 128);
    rst_n = 1'b0;
    #1;
    chk("arst_mean", mean, 0);
    chk("arst_bcd", bcd, 0);
    chk("arst_busy", busy, 0);
    chk("arst_vld", bvld, 0);
    chk("arst_blank", blank, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (bvld) pulses++;
    end
    chk("arst_no_vld", pulses, 0);
    strobes(4, {8'd64, 8'd64, 8'd64, 8'd64});
    wait_vld(lat, b1);
    chk("post_rst_lat", lat, 16);
    chk("post_rst_bcd", bcd, 16'h1250);

    // AVG_LOG2=0, VREF_MV=10000: one strobe is a full window.
    @(posedge clk); #1;
    vld2 = 1'b1; smp2 = 8'd255;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        vld2 = 1'b0;
        chk("a0_mean", mean2, 255);
        chk("a0_busy", busy2, 1);
      end
      if (bvld2) begin
        lat = n;
        break;
      end
    end
    chk("a0_lat", lat, 16);
    chk("a0_bcd", bcd2, 16'h9960);

    // Partial window held across a long idle gap.
    strobes(3, {8'd4, 8'd4, 8'd4, 8'd0});
    @(posedge clk); #1;
    vld = 1'b0;
    pulses = 0;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk); #1;
      if (bvld || busy) pulses++;
    end
    chk("gap_quiet", pulses, 0);
    chk("gap_mean_held", mean, 64);
    strobes(1, {8'd0, 8'd0, 8'd0, 8'd0});
    wait_vld(lat, b1);
    chk("gap_lat", lat, 16);
    chk("gap_mean", mean, 3);
    chk("gap_bcd", bcd, 16'h0058);
    chk("gap_blank", blank, exp_blank(4'b1100));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
